// File: rtl/sdrc_bank_arb.sv
// Bank command arbiter: picks one of four bank FSM commands into a registered slot for xfr_ctl.
// Reads/writes beat precharge/activate; round-robin from rr_q inside each tier.
module sdrc_bank_arb #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned LEN_W = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           bank_req,
  input  logic [7:0]           bank_cmd,
  input  logic [51:0]          bank_addr,
  input  logic [4*ID_W-1:0]    bank_id,
  input  logic [4*LEN_W-1:0]   bank_len,
  input  logic [3:0]           bank_start,
  input  logic [3:0]           bank_last,
  input  logic [3:0]           bank_wrap,
  output logic [3:0]           bank_ack,
  output logic                 x_req,
  output logic [1:0]           x_cmd,
  output logic [12:0]          x_addr,
  output logic [1:0]           x_ba,
  output logic [ID_W-1:0]      x_id,
  output logic [LEN_W-1:0]     x_len,
  output logic                 x_start,
  output logic                 x_last,
  output logic                 x_wrap,
  input  logic                 x_ack,
  input  logic                 x_refresh
);

  logic              slot_v_q;
  logic [1:0]        slot_bank_q;
  logic [1:0]        slot_cmd_q;
  logic [12:0]       slot_addr_q;
  logic [ID_W-1:0]   slot_id_q;
  logic [LEN_W-1:0]  slot_len_q;
  logic              slot_start_q, slot_last_q, slot_wrap_q;
  logic [1:0]        rr_q;

  logic [1:0]        cmd_arr  [4];
  logic [12:0]       addr_arr [4];
  logic [ID_W-1:0]   id_arr   [4];
  logic [LEN_W-1:0]  len_arr  [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cmd_arr[i]  = bank_cmd[2*i +: 2];
      addr_arr[i] = bank_addr[13*i +: 13];
      id_arr[i]   = bank_id[ID_W*i +: ID_W];
      len_arr[i]  = bank_len[LEN_W*i +: LEN_W];
    end
  end

  logic accept, cancel, load;
  logic [3:0] elig, elig_a, elig_b;
  logic found_a, found_b;
  logic [1:0] win_a, win_b, win, idx;

  assign accept = slot_v_q & x_ack;
  assign cancel = slot_v_q & ~x_ack &
                  (~bank_req[slot_bank_q] | (cmd_arr[slot_bank_q] != slot_cmd_q));

  // Refresh wins over the ack, so the owner must not see an ack for a flushed slot.
  assign bank_ack = (accept & ~x_refresh) ? (4'b0001 << slot_bank_q) : 4'b0000;

  always_comb begin
    elig = bank_req;
    // A bank freed this cycle still shows its old request; keep it out of the race.
    if (accept | cancel) elig[slot_bank_q] = 1'b0;
    // RD/WR encodings both have bit 1 set.
    for (int i = 0; i < 4; i++) begin
      elig_a[i] = elig[i] & cmd_arr[i][1];
      elig_b[i] = elig[i] & ~cmd_arr[i][1];
    end
  end

  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    win_a   = 2'd0;
    win_b   = 2'd0;
    idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found_a && elig_a[idx]) begin
        found_a = 1'b1;
        win_a   = idx;
      end
      if (!found_b && elig_b[idx]) begin
        found_b = 1'b1;
        win_b   = idx;
      end
    end
    win = found_a ? win_a : win_b;
  end

  assign load = (~slot_v_q | accept | cancel) & ~x_refresh & (found_a | found_b);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_v_q     <= 1'b0;
      slot_bank_q  <= 2'd0;
      slot_cmd_q   <= 2'd0;
      slot_addr_q  <= 13'd0;
      slot_id_q    <= '0;
      slot_len_q   <= '0;
      slot_start_q <= 1'b0;
      slot_last_q  <= 1'b0;
      slot_wrap_q  <= 1'b0;
      rr_q         <= 2'd0;
    end else begin
      if (load) begin
        slot_v_q     <= 1'b1;
        slot_bank_q  <= win;
        slot_cmd_q   <= cmd_arr[win];
        slot_addr_q  <= addr_arr[win];
        slot_id_q    <= id_arr[win];
        slot_len_q   <= len_arr[win];
        slot_start_q <= bank_start[win];
        slot_last_q  <= bank_last[win];
        slot_wrap_q  <= bank_wrap[win];
        rr_q         <= win + 2'd1;
      end else if (x_refresh | accept | cancel) begin
        slot_v_q <= 1'b0;
      end
    end
  end

  assign x_req   = slot_v_q;
  assign x_cmd   = slot_cmd_q;
  assign x_addr  = slot_addr_q;
  assign x_ba    = slot_bank_q;
  assign x_id    = slot_id_q;
  assign x_len   = slot_len_q;
  assign x_start = slot_start_q;
  assign x_last  = slot_last_q;
  assign x_wrap  = slot_wrap_q;

endmodule

// File: tb/tb_sdrc_bank_arb.sv
// Scoreboard bench for sdrc_bank_arb: a ranking model predicts x_req and acks per cycle,
// a negedge monitor pops and compares.
module tb_sdrc_bank_arb;

  localparam logic [1:0] OP_PRE = 2'b00;
  localparam logic [1:0] OP_ACT = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_WR  = 2'b11;

  typedef struct packed {
    logic [1:0]  ba;
    logic [1:0]  cmd;
    logic [12:0] addr;
    logic [3:0]  id;
    logic [11:0] len;
    logic        start;
    logic        last;
    logic        wrap;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  bank_req = '0;
  logic [7:0]  bank_cmd = '0;
  logic [51:0] bank_addr = '0;
  logic [15:0] bank_id = '0;
  logic [47:0] bank_len = '0;
  logic [3:0]  bank_start = '0, bank_last = '0, bank_wrap = '0;
  logic [3:0]  bank_ack;
  logic        x_req, x_start, x_last, x_wrap;
  logic [1:0]  x_cmd, x_ba;
  logic [12:0] x_addr;
  logic [3:0]  x_id;
  logic [11:0] x_len;
  logic        x_ack = 1'b0, x_refresh = 1'b0;

  sdrc_bank_arb #(.ID_W(4), .LEN_W(12)) dut (
    .clk(clk), .reset_n(reset_n),
    .bank_req(bank_req), .bank_cmd(bank_cmd), .bank_addr(bank_addr), .bank_id(bank_id),
    .bank_len(bank_len), .bank_start(bank_start), .bank_last(bank_last),
    .bank_wrap(bank_wrap), .bank_ack(bank_ack),
    .x_req(x_req), .x_cmd(x_cmd), .x_addr(x_addr), .x_ba(x_ba), .x_id(x_id),
    .x_len(x_len), .x_start(x_start), .x_last(x_last), .x_wrap(x_wrap),
    .x_ack(x_ack), .x_refresh(x_refresh)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Per-bank stimulus state
  bit          b_req[4];
  logic [1:0]  b_cmd[4];
  logic [12:0] b_addr[4];
  logic [3:0]  b_id[4];
  logic [11:0] b_len[4];
  bit          b_start[4], b_last[4], b_wrap[4];

  // Reference model state
  bit   m_v = 1'b0;
  int   m_rr = 0;
  rec_t m_slot = '0;
  int   last_ack = -1;

  bit   q_xreq[$];
  rec_t q_ack[$];

  task automatic pack();
    for (int i = 0; i < 4; i++) begin
      bank_req[i]           = b_req[i];
      bank_cmd[2*i +: 2]    = b_cmd[i];
      bank_addr[13*i +: 13] = b_addr[i];
      bank_id[4*i +: 4]     = b_id[i];
      bank_len[12*i +: 12]  = b_len[i];
      bank_start[i]         = b_start[i];
      bank_last[i]          = b_last[i];
      bank_wrap[i]          = b_wrap[i];
    end
  endtask

  task automatic set_bank(input int i, input bit req, input logic [1:0] cmd,
                          input logic [12:0] addr);
    b_req[i]   = req;
    b_cmd[i]   = cmd;
    b_addr[i]  = addr;
    b_id[i]    = 4'(i + 5);
    b_len[i]   = 12'(addr) + 12'(i);
    b_start[i] = addr[0];
    b_last[i]  = addr[1];
    b_wrap[i]  = addr[2];
  endtask

  task automatic rand_bank(input int i);
    b_req[i]   = ($urandom_range(0, 3) != 0);
    b_cmd[i]   = 2'($urandom);
    b_addr[i]  = 13'($urandom);
    b_id[i]    = 4'($urandom);
    b_len[i]   = 12'($urandom);
    b_start[i] = 1'($urandom);
    b_last[i]  = 1'($urandom);
    b_wrap[i]  = 1'($urandom);
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) set_bank(i, 1'b0, OP_PRE, 13'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply this cycle's inputs, queue expected outputs, then advance the model one clock.
  task automatic eval(input bit ack, input bit rfsh);
    int gone, best, best_key, key;
    x_ack = ack;
    x_refresh = rfsh;
    pack();
    q_xreq.push_back(m_v);
    last_ack = -1;
    if (m_v && ack && !rfsh) begin
      q_ack.push_back(m_slot);
      last_ack = int'(m_slot.ba);
    end
    if (rfsh) begin
      m_v = 1'b0;
    end else begin
      gone = -1;
      if (m_v && (ack || !b_req[m_slot.ba] || b_cmd[m_slot.ba] != m_slot.cmd))
        gone = int'(m_slot.ba);
      if (!m_v || gone >= 0) begin
        best = -1;
        best_key = 100;
        for (int i = 0; i < 4; i++) begin
          if (b_req[i] && i != gone) begin
            // Rank: tier first (RD/WR before PRE/ACT), then distance from the pointer.
            key = ((b_cmd[i] == OP_RD || b_cmd[i] == OP_WR) ? 0 : 4) + (i - m_rr + 4) % 4;
            if (key < best_key) begin
              best_key = key;
              best = i;
            end
          end
        end
        m_v = (best >= 0);
        if (best >= 0) begin
          m_slot.ba    = 2'(best);
          m_slot.cmd   = b_cmd[best];
          m_slot.addr  = b_addr[best];
          m_slot.id    = b_id[best];
          m_slot.len   = b_len[best];
          m_slot.start = b_start[best];
          m_slot.last  = b_last[best];
          m_slot.wrap  = b_wrap[best];
          m_rr = (best + 1) % 4;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (x_req !== 1'b0 || bank_ack !== 4'b0 || x_ba !== 2'd0 || x_cmd !== 2'd0 ||
        x_addr !== 13'd0) begin
      failures++;
      $display("FAIL reset_state got req=%b ack=%b ba=%0d cmd=%0d addr=%h exp all zero",
               x_req, bank_ack, x_ba, x_cmd, x_addr);
    end
    m_v = 1'b0;
    m_rr = 0;
    clear_all();
    x_ack = 1'b0;
    x_refresh = 1'b0;
    pack();
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor
  bit   mon_req;
  rec_t mon_exp, mon_act;
  always @(negedge clk) begin
    if (q_xreq.size() != 0) begin
      mon_req = q_xreq.pop_front();
      checks++;
      if (x_req !== mon_req) begin
        failures++;
        $display("FAIL x_req t=%0t got=%b exp=%b", $time, x_req, mon_req);
      end
      if (q_ack.size() != 0) begin
        mon_exp = q_ack.pop_front();
        checks++;
        if (bank_ack !== (4'b0001 << mon_exp.ba)) begin
          failures++;
          $display("FAIL bank_ack t=%0t got=%b exp=%b", $time, bank_ack,
                   4'b0001 << mon_exp.ba);
        end
        mon_act = {x_ba, x_cmd, x_addr, x_id, x_len, x_start, x_last, x_wrap};
        checks++;
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL slot_fields t=%0t got=%h exp=%h", $time, mon_act, mon_exp);
        end
      end else begin
        checks++;
        if (bank_ack !== 4'b0000) begin
          failures++;
          $display("FAIL bank_ack_idle t=%0t got=%b exp=0000", $time, bank_ack);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clear_all();
    pack();
    do_reset();

    // Single WR on bank 2
    tick(); set_bank(2, 1'b1, OP_WR, 13'h055); eval(1'b0, 1'b0);
    tick(); eval(1'b1, 1'b0);
    tick(); b_req[2] = 1'b0; eval(1'b0, 1'b0);

    // Banks 0,1,3 read with x_ack held high: no bubbles
    do_reset();
    tick();
    set_bank(0, 1'b1, OP_RD, 13'h100);
    set_bank(1, 1'b1, OP_RD, 13'h101);
    set_bank(3, 1'b1, OP_RD, 13'h103);
    for (int n = 0; n < 8; n++) begin
      eval(1'b1, 1'b0);
      tick();
    end
    clear_all(); eval(1'b0, 1'b0);

    // Tier priority: bank 1 RD beats bank 0 PRE
    do_reset();
    tick();
    set_bank(0, 1'b1, OP_PRE, 13'h0a0);
    set_bank(1, 1'b1, OP_RD, 13'h0b1);
    eval(1'b0, 1'b0);
    tick(); eval(1'b0, 1'b0);
    tick(); eval(1'b1, 1'b0);
    tick(); b_req[1] = 1'b0; eval(1'b1, 1'b0);
    tick(); b_req[0] = 1'b0; eval(1'b0, 1'b0);

    // Cancel: bank 3 drops its request while held
    do_reset();
    tick(); set_bank(3, 1'b1, OP_ACT, 13'h1f3); eval(1'b0, 1'b0);
    tick(); eval(1'b0, 1'b0);
    tick(); b_req[3] = 1'b0; eval(1'b0, 1'b0);
    tick(); eval(1'b0, 1'b0);
    // Cancel by command change
    tick(); set_bank(3, 1'b1, OP_ACT, 13'h033); eval(1'b0, 1'b0);
    tick(); b_cmd[3] = OP_WR; eval(1'b0, 1'b0);
    tick(); eval(1'b1, 1'b0);
    tick(); clear_all(); eval(1'b0, 1'b0);

    // Refresh beats ack and blocks a load that cycle
    do_reset();
    tick(); set_bank(0, 1'b1, OP_WR, 13'h0c0); eval(1'b0, 1'b0);
    tick(); eval(1'b1, 1'b1);
    tick(); eval(1'b1, 1'b0);
    tick(); eval(1'b1, 1'b0);
    tick(); clear_all(); eval(1'b0, 1'b0);

    // Async reset mid-hold, then scan restarts at bank 0
    do_reset();
    tick(); set_bank(1, 1'b1, OP_RD, 13'h0d1); eval(1'b0, 1'b0);
    tick(); eval(1'b0, 1'b0);
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) set_bank(i, 1'b1, OP_RD, 13'(16'h0200 + i));
    eval(1'b0, 1'b0);
    tick(); b_req[3] = 1'b0; eval(1'b1, 1'b0);
    tick(); clear_all(); eval(1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 4; i++) rand_bank(i);
    for (int n = 0; n < 800; n++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (i == last_ack || $urandom_range(0, 7) == 0) rand_bank(i);
      end
      eval($urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
    end

    tick(); clear_all(); eval(1'b0, 1'b0);
    tick(); eval(1'b0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (q_ack.size() != 0 || q_xreq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d/%0d pending exp=0/0", q_xreq.size(), q_ack.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
